multiplier: RTL and testbench

Iterative shift-add 64-bit integer multiplier for the nonpipelined LEGv8 core. It is the responder side of the `mult_start`/`multiplier_done` handshake driven by the decode control unit. While a `MUL` is in decode, control holds `mult_start` high and freezes the PC. This block captures the operands, iterates one multiplier bit per cycle, and returns the low 64 bits of the product with a one-cycle `multiplier_done` pulse. Execute selects `mult_result` as the write-back value when `execute_result_loc` is set.

---
 rtl/multiplier.sv | 91 +++++++++
 tb/tb_multiplier.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/multiplier.sv
`default_nettype none
// ============================================================================
// Module  : multiplier
// Brief   : Iterative shift-add integer multiplier, one multiplier bit per
//           cycle, with early exit once the remaining multiplier bits are zero.
// Revision: 1.0 - initial release
// ============================================================================
module multiplier #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mult_start,
    input  logic [WIDTH-1:0] mult_a,
    input  logic [WIDTH-1:0] mult_b,
    output logic             multiplier_done,
    output logic [WIDTH-1:0] mult_result,
    output logic             mult_busy
);

    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CW-1:0] c_last_count = CW'(WIDTH - 1);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplr;
    logic [WIDTH-1:0] r_result;
    logic [CW-1:0]    r_count;

    logic [WIDTH-1:0] w_acc_next;
    logic             w_last_iter;

    assign w_acc_next  = r_mplr[0] ? (r_acc + r_mcand) : r_acc;
    // Stop once no set multiplier bits remain above the one consumed now.
    assign w_last_iter = ((r_mplr >> 1) == '0) || (r_count == c_last_count);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplr   <= '0;
            r_result <= '0;
            r_count  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (mult_start) begin
                        r_mcand <= mult_a;
                        r_mplr  <= mult_b;
                        r_acc   <= '0;
                        r_count <= '0;
                        r_state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (!mult_start) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_acc   <= w_acc_next;
                        r_mcand <= r_mcand << 1;
                        r_mplr  <= r_mplr >> 1;
                        r_count <= r_count + 1'b1;
                        if (w_last_iter) begin
                            r_result <= w_acc_next;
                            r_state  <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign multiplier_done = (r_state == S_DONE);
    assign mult_busy       = (r_state == S_BUSY);
    assign mult_result     = r_result;

endmodule
`default_nettype wire

// File: tb/tb_multiplier.sv
`default_nettype none
// ============================================================================
// Module  : tb_multiplier
// Brief   : Directed scoreboard bench for the shift-add multiplier.
// Revision: 1.0 - initial release
// ============================================================================
module tb_multiplier;

    localparam int WIDTH = 64;

    logic             clk = 1'b0;
    logic             reset;
    logic             mult_start;
    logic [WIDTH-1:0] mult_a;
    logic [WIDTH-1:0] mult_b;
    logic             multiplier_done;
    logic [WIDTH-1:0] mult_result;
    logic             mult_busy;

    int               n_cmp  = 0;
    int               n_fail = 0;
    logic [WIDTH-1:0] q_exp[$];
    logic [WIDTH-1:0] last_result;

    always #5 clk = ~clk;

    multiplier #(.WIDTH(WIDTH)) dut (
        .clk             (clk),
        .reset           (reset),
        .mult_start      (mult_start),
        .mult_a          (mult_a),
        .mult_b          (mult_b),
        .multiplier_done (multiplier_done),
        .mult_result     (mult_result),
        .mult_busy       (mult_busy)
    );

    task automatic chk(input string tag, input logic [WIDTH-1:0] got,
                       input logic [WIDTH-1:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Expected BUSY cycles: max(1, index of highest set bit + 1).
    function automatic int busy_model(input logic [WIDTH-1:0] b);
        int n;
        n = 1;
        for (int i = 0; i < WIDTH; i++)
            if (b[i]) n = i + 1;
        return n;
    endfunction

    task automatic do_mul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input bit hold);
        int               exp_n;
        int               busy_cnt;
        bit               got;
        logic [WIDTH-1:0] exp_v;
        exp_n = busy_model(b);
        @(negedge clk);
        chk("done_low_before_start", 64'(multiplier_done), 64'd0);
        mult_a     = a;
        mult_b     = b;
        mult_start = 1'b1;
        q_exp.push_back(a * b);
        busy_cnt = 0;
        got      = 1'b0;
        for (int i = 0; i < WIDTH + 8 && !got; i++) begin
            @(negedge clk);
            if (i == 0) begin
                mult_a = ~a;
                mult_b = ~b;
            end
            if (mult_busy) busy_cnt++;
            if (multiplier_done) begin
                got   = 1'b1;
                exp_v = q_exp.pop_front();
                chk("result", mult_result, exp_v);
                chk("busy_cycles", 64'(busy_cnt), 64'(exp_n));
                chk("busy_low_in_done", 64'(mult_busy), 64'd0);
                last_result = exp_v;
                if (!hold) mult_start = 1'b0;
            end
        end
        if (!got) begin
            chk("done_timeout", 64'd0, 64'd1);
            if (q_exp.size() > 0) void'(q_exp.pop_front());
            mult_start = 1'b0;
        end
        if (hold) begin
            @(negedge clk);
            chk("no_capture_in_done", 64'(mult_busy), 64'd0);
            chk("done_single_cycle", 64'(multiplier_done), 64'd0);
            mult_start = 1'b0;
        end
    endtask

    initial begin
        int d_cnt;
        reset       = 1'b1;
        mult_start  = 1'b0;
        mult_a      = '0;
        mult_b      = '0;
        last_result = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_done", 64'(multiplier_done), 64'd0);
        chk("reset_busy", 64'(mult_busy), 64'd0);
        chk("reset_result", mult_result, 64'd0);

        // Basic, zero, early exit, with one op holding start through DONE.
        do_mul(64'd7, 64'd6, 1'b0);
        do_mul(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0);
        do_mul(64'h1234, 64'd1, 1'b1);

        // Full width wrap and a negative operand.
        do_mul(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        do_mul(64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 1'b0);

        // Abort after two BUSY cycles.
        @(negedge clk);
        mult_a     = 64'd3;
        mult_b     = 64'h80;
        mult_start = 1'b1;
        @(negedge clk);
        chk("abort_busy1", 64'(mult_busy), 64'd1);
        @(negedge clk);
        chk("abort_busy2", 64'(mult_busy), 64'd1);
        mult_start = 1'b0;
        d_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 0) chk("abort_idle", 64'(mult_busy), 64'd0);
            if (multiplier_done) d_cnt++;
        end
        chk("abort_no_done", 64'(d_cnt), 64'd0);
        chk("abort_result_held", mult_result, last_result);
        do_mul(64'd3, 64'h80, 1'b0);

        // Back-to-back requests.
        do_mul(64'd5, 64'd5, 1'b0);
        do_mul(64'd9, 64'd3, 1'b0);

        // Asynchronous reset in the middle of a long operation.
        @(negedge clk);
        mult_a     = 64'hFFFF_FFFF_FFFF_FFFF;
        mult_b     = 64'hFFFF_FFFF_FFFF_FFFF;
        mult_start = 1'b1;
        repeat (10) @(negedge clk);
        chk("pre_reset_busy", 64'(mult_busy), 64'd1);
        #2 reset = 1'b1;
        #1;
        chk("async_reset_done", 64'(multiplier_done), 64'd0);
        chk("async_reset_busy", 64'(mult_busy), 64'd0);
        chk("async_reset_result", mult_result, 64'd0);
        last_result = '0;
        @(negedge clk);
        mult_start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        d_cnt = 0;
        for (int i = 0; i < WIDTH + 6; i++) begin
            @(negedge clk);
            if (multiplier_done) d_cnt++;
        end
        chk("reset_no_done", 64'(d_cnt), 64'd0);
        do_mul(64'd2, 64'd2, 1'b0);

        @(negedge clk);
        chk("final_done_low", 64'(multiplier_done), 64'd0);
        chk("scoreboard_empty", 64'(q_exp.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
